key_event_queue: RTL and testbench
==================================

# key_event_queue

Parametrised input-event front end between the keyboard decoder and debounced buttons and `terminal_controller`. It suppresses typematic auto-repeat by requiring a BREAK between presses, generalised to any number of keys and buttons. It detects button rising edges across `NUM_BTNS` channels and arbitrates all sources into one event stream. Events are buffered in a FIFO with a valid/ready handshake, so no press is lost while the terminal is busy.

## Interface
Parameters:
- `NUM_BTNS`, 3: number of debounced button channels (1–8).
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `FILTER_REPEAT`, 1: 1 drops presses not preceded by BREAK; 0 passes every press.

Ports. One clock; reset is synchronous and active-high.
- `pixel_clk_in`  in  1  system pixel clock; all state on its rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `kb_valid_in`  in  1  one-cycle pulse; a keyboard event is present.
- `kb_kind_in`  in  2  `key_type_t`: KEY=0, BREAK=1, ENTER=2, BKSP=3.
- `kb_code_in`  in  8  translated character code; meaningful for KEY only.
- `btn_in`  in  NUM_BTNS  debounced button levels.
- `ev_valid_out`  out  1  FIFO head is valid.
- `ev_ready_in`  in  1  consumer accepts the head when this and `ev_valid_out` are both high.
- `ev_kind_out`  out  2  `ev_kind_t`: CHAR=0, BUTTON=1, ENTER=2, BKSP=3.
- `ev_data_out`  out  8  CHAR: code; BUTTON: button index; ENTER/BKSP: 0.
- `fill_out`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_out`  out  1  sticky; a keyboard event was dropped because the FIFO was full.
- `clear_overflow_in`  in  1  clears `overflow_out`.

## Operation
- **Repeat filter:** a single `armed` bit.
  - Reset value is 1.
  - BREAK sets `armed`=1 and emits nothing.
  - KEY, ENTER or BKSP with `armed`=1 is a candidate; `armed` then clears.
  - KEY, ENTER or BKSP with `armed`=0 is discarded when FILTER_REPEAT=1.
  - With FILTER_REPEAT=0, every KEY, ENTER or BKSP is a candidate and `armed` is ignored.
- **Buttons:**
  - `btn_prev` is registered every cycle. During reset it loads `btn_in`, so a button held through reset produces no event.
  - A rising edge on bit i sets `pending[i]`.
  - `pending[i]` clears only when its event is pushed.
  - An edge arriving while `pending[i]` is already set merges into the same event.
- **Arbiter:** at most one push per cycle.
  - A keyboard candidate has priority, because it is a pulse that cannot be held.
  - Otherwise the lowest-index set `pending` bit is pushed.
- **Push acceptance:** a push is accepted when `fill_out` < DEPTH, or when the FIFO is full and a pop happens in the same cycle.
- **Rejected push:**
  - A rejected keyboard candidate is dropped and sets `overflow_out`. `armed` still clears, so a later BREAK is needed before the next press.
  - A rejected button push leaves `pending` set and retries the next cycle.
- **Overflow flag:** `clear_overflow_in` clears `overflow_out`. If a clear and a new drop happen in the same cycle, the set wins.
- **Reset values:** `ev_valid_out`=0, `fill_out`=0, `overflow_out`=0, `ev_kind_out`=0, `ev_data_out`=0, `pending`=0, `armed`=1. Read and write pointers are 0.
- **Reset mid-operation:** all queued events are discarded and pending presses are lost.

## Timing
- Input-to-output latency is one cycle. An accepted push in cycle t gives `ev_valid_out`=1 in cycle t+1 when the FIFO was empty.
- The FIFO is show-ahead: the head is on `ev_kind_out`/`ev_data_out` whenever `ev_valid_out`=1. Head fields hold stable until popped.
- A pop at cycle t presents the next entry at t+1.
- Simultaneous push and pop leaves `fill_out` unchanged.
- Pointers wrap modulo DEPTH.
- `ev_ready_in` while `ev_valid_out`=0 is ignored.
- Button edge to push: the edge is seen at cycle t and pushed at t+1 if no keyboard candidate is present. It is visible at the output at t+2 at the earliest.
- Throughput is one event per cycle in and one out.

## Structure
- Package `key_event_pkg` holds `key_type_t`, `ev_kind_t`, and a packed `key_event_t` struct (kind, data).
- Sub-module `event_fifo`: a synchronous show-ahead FIFO parametrised by DEPTH and element type. It exposes full, empty and count.
- The filter, edge detect and arbiter stay in the top module.

## Test plan
- After reset, KEY 0x41, then BREAK, then KEY 0x42 → two CHAR events, 0x41 then 0x42. Each appears one cycle after its input.
- KEY 0x41 repeated five times with no BREAK, FILTER_REPEAT=1 → one CHAR 0x41. Repeat with FILTER_REPEAT=0 → five events.
- `btn_in` rises on bits 0 and 2 in the same cycle as KEY 0x30 → queue order is CHAR 0x30, BUTTON 0, BUTTON 2.
- `ev_ready_in`=0, DEPTH=8, nine armed KEY presses separated by BREAKs → `fill_out`=8, `overflow_out`=1, and draining yields the first eight codes in order. `clear_overflow_in` then drops the flag.
- FIFO full, a button edge arrives, then `ev_ready_in` pulses for one cycle → the button event is pushed in the pop cycle and `fill_out` stays 8.
- Assert `rst_in` with three queued events and a button held → `ev_valid_out`=0 and `fill_out`=0 next cycle. There is no BUTTON event after reset release while the button stays held.

Source files
------------

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared types for the key event front end
package key_event_pkg;

    typedef enum logic [1:0] {
        KT_KEY   = 2'd0,
        KT_BREAK = 2'd1,
        KT_ENTER = 2'd2,
        KT_BKSP  = 2'd3
    } key_type_t;

    typedef enum logic [1:0] {
        EV_CHAR   = 2'd0,
        EV_BUTTON = 2'd1,
        EV_ENTER  = 2'd2,
        EV_BKSP   = 2'd3
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } key_event_t;

    // Only KEY carries a code; ENTER and BKSP report zero data.
    function automatic key_event_t kb_to_event(key_type_t kt, logic [7:0] code);
        key_event_t ev;
        case (kt)
            KT_KEY:   ev = '{kind: EV_CHAR,  data: code};
            KT_ENTER: ev = '{kind: EV_ENTER, data: 8'h00};
            KT_BKSP:  ev = '{kind: EV_BKSP,  data: 8'h00};
            default:  ev = '{kind: EV_CHAR,  data: 8'h00};
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous show-ahead FIFO, push accepted when full if popping
module event_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [9:0]
) (
    input  logic                     clk_pixel,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output T                         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    // Head reads zero while empty so the outputs never expose stale entries.
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_pixel) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - repeat filter, button edge detect and arbiter feeding an event FIFO
module key_event_queue
    import key_event_pkg::*;
#(
    parameter int NUM_BTNS      = 3,
    parameter int DEPTH         = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                       pixel_clk_in,
    input  logic                       rst_in,
    input  logic                       kb_valid_in,
    input  logic [1:0]                 kb_kind_in,
    input  logic [7:0]                 kb_code_in,
    input  logic [NUM_BTNS-1:0]        btn_in,
    output logic                       ev_valid_out,
    input  logic                       ev_ready_in,
    output logic [1:0]                 ev_kind_out,
    output logic [7:0]                 ev_data_out,
    output logic [$clog2(DEPTH):0]     fill_out,
    output logic                       overflow_out,
    input  logic                       clear_overflow_in
);
    key_type_t             kb_kind;
    logic                  kb_press;
    logic                  kb_cand;
    logic                  armed;
    logic [NUM_BTNS-1:0]   btn_prev;
    logic [NUM_BTNS-1:0]   pending;
    logic [NUM_BTNS-1:0]   btn_rise;
    logic [NUM_BTNS-1:0]   btn_grant;
    logic [NUM_BTNS-1:0]   btn_clear;
    logic                  btn_any;
    logic [7:0]            btn_idx;
    logic                  push;
    logic                  push_ok;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    key_event_t            push_ev;
    key_event_t            head_ev;

    assign kb_kind  = key_type_t'(kb_kind_in);
    assign kb_press = kb_valid_in && (kb_kind != KT_BREAK);
    assign kb_cand  = kb_press && (armed || (FILTER_REPEAT == 0));
    assign btn_rise = btn_in & ~btn_prev;

    // Lowest-index pending button wins when the keyboard is idle.
    always_comb begin
        btn_grant = '0;
        btn_idx   = 8'h00;
        btn_any   = 1'b0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            if (pending[i] && !btn_any) begin
                btn_any      = 1'b1;
                btn_grant[i] = 1'b1;
                btn_idx      = 8'(i);
            end
        end
    end

    assign pop       = ev_ready_in && !fifo_empty;
    assign push_ok   = !fifo_full || pop;
    assign push      = kb_cand || btn_any;
    assign push_ev   = kb_cand ? kb_to_event(kb_kind, kb_code_in)
                               : '{kind: EV_BUTTON, data: btn_idx};
    assign btn_clear = (!kb_cand && push_ok) ? btn_grant : '0;

    always_ff @(posedge pixel_clk_in) begin
        // Loading during reset hides buttons already held through it.
        btn_prev <= btn_in;
        if (rst_in) begin
            armed        <= 1'b1;
            pending      <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (kb_valid_in && kb_kind == KT_BREAK) begin
                armed <= 1'b1;
            end else if (kb_press) begin
                armed <= 1'b0;
            end
            pending <= (pending & ~btn_clear) | btn_rise;
            if (kb_cand && !push_ok) begin
                overflow_out <= 1'b1;
            end else if (clear_overflow_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .T     (key_event_t)
    ) u_fifo (
        .clk_pixel (pixel_clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data (push_ev),
        .pop       (pop),
        .head      (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_out)
    );

    assign ev_valid_out = !fifo_empty;
    assign ev_kind_out  = head_ev.kind;
    assign ev_data_out  = head_ev.data;

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed self-checking bench for key_event_queue
module tb_key_event_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_valid = 1'b0;
    logic [1:0] kb_kind = 2'd0;
    logic [7:0] kb_code = 8'h00;
    logic [2:0] btn = 3'b000;
    logic       ready = 1'b0;
    logic       clr_ovf = 1'b0;

    logic       valid, nf_valid;
    logic [1:0] kind, nf_kind;
    logic [7:0] data, nf_data;
    logic [3:0] fill, nf_fill;
    logic       ovf, nf_ovf;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    key_event_queue #(.NUM_BTNS(3), .DEPTH(8), .FILTER_REPEAT(1)) dut (
        .pixel_clk_in (clk), .rst_in (rst),
        .kb_valid_in (kb_valid), .kb_kind_in (kb_kind), .kb_code_in (kb_code),
        .btn_in (btn),
        .ev_valid_out (valid), .ev_ready_in (ready),
        .ev_kind_out (kind), .ev_data_out (data),
        .fill_out (fill), .overflow_out (ovf), .clear_overflow_in (clr_ovf)
    );

    key_event_queue #(.NUM_BTNS(3), .DEPTH(8), .FILTER_REPEAT(0)) dut_nf (
        .pixel_clk_in (clk), .rst_in (rst),
        .kb_valid_in (kb_valid), .kb_kind_in (kb_kind), .kb_code_in (kb_code),
        .btn_in (btn),
        .ev_valid_out (nf_valid), .ev_ready_in (1'b0),
        .ev_kind_out (nf_kind), .ev_data_out (nf_data),
        .fill_out (nf_fill), .overflow_out (nf_ovf), .clear_overflow_in (clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kb(input logic [1:0] k, input logic [7:0] c);
        kb_valid = 1'b1;
        kb_kind  = k;
        kb_code  = c;
        step();
        kb_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pop_one(input string tag, input logic [1:0] k, input logic [7:0] d);
        chk({tag, "_valid"}, valid, 1'b1);
        chk({tag, "_kind"}, kind, k);
        chk({tag, "_data"}, data, d);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("rst_valid", valid, 1'b0);
        chk("rst_fill", fill, 4'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_kind", kind, 2'd0);
        chk("rst_data", data, 8'h00);

        // KEY 41, BREAK, KEY 42
        kb(2'd0, 8'h41);
        chk("t1_valid_lat", valid, 1'b1);
        chk("t1_head_41", data, 8'h41);
        kb(2'd1, 8'h00);
        chk("t1_break_fill", fill, 4'd1);
        kb(2'd0, 8'h42);
        chk("t1_fill2", fill, 4'd2);
        pop_one("t1_e0", 2'd0, 8'h41);
        pop_one("t1_e1", 2'd0, 8'h42);
        chk("t1_empty", valid, 1'b0);

        // Auto-repeat: five KEY 41 without BREAK
        do_reset();
        kb(2'd1, 8'h00);
        for (int i = 0; i < 5; i++) kb(2'd0, 8'h41);
        chk("t2_filt_fill", fill, 4'd1);
        chk("t2_nofilt_fill", nf_fill, 4'd5);
        pop_one("t2_e0", 2'd0, 8'h41);
        chk("t2_empty", valid, 1'b0);

        // Buttons 0 and 2 rise with KEY 30
        do_reset();
        btn = 3'b101;
        kb(2'd0, 8'h30);
        step(2);
        chk("t3_fill", fill, 4'd3);
        pop_one("t3_e0", 2'd0, 8'h30);
        pop_one("t3_e1", 2'd1, 8'h00);
        pop_one("t3_e2", 2'd1, 8'h02);
        chk("t3_empty", fill, 4'd0);
        btn = 3'b000;
        step();

        // Overflow with nine armed presses
        do_reset();
        for (int i = 0; i < 9; i++) begin
            kb(2'd1, 8'h00);
            kb(2'd0, 8'(8'h50 + i));
            if (i == 7) chk("t4_ovf_before", ovf, 1'b0);
        end
        chk("t4_fill8", fill, 4'd8);
        chk("t4_ovf_set", ovf, 1'b1);
        for (int i = 0; i < 8; i++) pop_one("t4_drain", 2'd0, 8'(8'h50 + i));
        chk("t4_drained", fill, 4'd0);
        chk("t4_ovf_sticky", ovf, 1'b1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t4_ovf_clr", ovf, 1'b0);

        // Full FIFO, pending button pushed in the pop cycle
        for (int i = 0; i < 8; i++) begin
            kb(2'd1, 8'h00);
            kb(2'd0, 8'(8'h60 + i));
        end
        btn = 3'b010;
        step(3);
        chk("t5_full_hold", fill, 4'd8);
        chk("t5_no_ovf", ovf, 1'b0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t5_fill_pop_push", fill, 4'd8);
        step();
        chk("t5_fill_after", fill, 4'd8);
        for (int i = 1; i < 8; i++) pop_one("t5_drain", 2'd0, 8'(8'h60 + i));
        pop_one("t5_btn", 2'd1, 8'h01);
        chk("t5_drained", fill, 4'd0);

        // Reset mid-operation with button held
        for (int i = 0; i < 3; i++) begin
            kb(2'd1, 8'h00);
            kb(2'd0, 8'(8'h70 + i));
        end
        chk("t6_fill3", fill, 4'd3);
        btn = 3'b011;
        rst = 1'b1;
        step();
        chk("t6_rst_valid", valid, 1'b0);
        chk("t6_rst_fill", fill, 4'd0);
        rst = 1'b0;
        step(5);
        chk("t6_no_btn_fill", fill, 4'd0);
        chk("t6_no_btn_valid", valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
